// File: rtl/dm_copy_pkg.sv
// Shared types and default widths for the data-memory block-copy initiator.
// Contents: FSM state encoding dm_copy_state_t and the default address,
// data and length widths used as parameter defaults by dm_block_copy.
`timescale 1ns/1ps

package dm_copy_pkg;

  // Default widths: word-indexed address, data word, length counter.
  localparam int DM_AW = 32;
  localparam int DM_DW = 32;
  localparam int DM_LW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dm_copy_state_t;

endpackage : dm_copy_pkg

// File: rtl/dm_block_copy.sv
// Block-copy initiator: copies len words from src to dst through a single
// combinational-read / clocked-write data-memory port, one read cycle then one
// write cycle per word, framed by a start/busy/done handshake.
// Latency: done is high 2*len+1 cycles after the accepting edge (1 when len=0).
// Backpressure: none; start is only sampled in IDLE and is dropped otherwise.
// Ports: clk, rst_n (async active-low), start/src/dst/len (request),
//        busy/done (status), a/wd/we/rd (memory port),
//        checksum (only when DM_COPY_CHECKSUM_EN is defined).
// Optional feature macro: DM_COPY_CHECKSUM_EN adds a running sum of written words.
`timescale 1ns/1ps

import dm_copy_pkg::*;

module dm_block_copy #(
  parameter int AW = DM_AW,
  parameter int DW = DM_DW,
  parameter int LW = DM_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a,
  output logic [DW-1:0] wd,
  output logic          we,
  input  logic [DW-1:0] rd
`ifdef DM_COPY_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  dm_copy_state_t state, state_n;

  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;
  logic [LW-1:0] idx_inc;
  logic [DW-1:0] hold_q;
  logic          accept;

  // len never exceeds 2^LW-1, so idx+1 cannot wrap before it matches len.
  assign idx_inc = idx_q + LW'(1);
  assign accept  = (state == IDLE) && start;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (len != '0) ? READ : DONE;
        end
      end
      READ:  state_n = WRITE;
      WRITE: state_n = (idx_inc == len_q) ? DONE : READ;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured request, index counter and read-hold register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      hold_q <= '0;
    end else begin
      if (accept && (len != '0)) begin
        src_q <= src;
        dst_q <= dst;
        len_q <= len;
        idx_q <= '0;
      end
      if (state == READ) begin
        hold_q <= rd;
      end
      if (state == WRITE) begin
        idx_q <= idx_inc;
      end
    end
  end

`ifdef DM_COPY_CHECKSUM_EN
  // Sum of the words committed to memory; each WRITE edge commits hold_q.
  logic [DW-1:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (state == WRITE) begin
      checksum_q <= checksum_q + hold_q;
    end
  end

  assign checksum = checksum_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the state register and registered data only, so an
  // asynchronous reset forces we low immediately and nothing depends on start.
  // ---------------------------------------------------------------------------
  always_comb begin
    a = '0;
    unique case (state)
      READ:    a = src_q + AW'(idx_q);
      WRITE:   a = dst_q + AW'(idx_q);
      default: a = '0;
    endcase
  end

  assign wd   = hold_q;
  assign we   = (state == WRITE);
  assign busy = (state == READ) || (state == WRITE);
  assign done = (state == DONE);

endmodule : dm_block_copy

// File: tb/tb_dm_block_copy.sv
`timescale 1ns/1ps

module tb_dm_block_copy;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic          we;
  logic [DW-1:0] rd;
`ifdef DM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int checks;
  int errors;

  // Synchronous-write, combinational-read data memory (64 words).
  logic [DW-1:0] mem [0:63];

  assign rd = mem[a[5:0]];

  always @(posedge clk) begin
    if (we) mem[a[5:0]] <= wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dm_block_copy #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .a     (a),
    .wd    (wd),
    .we    (we),
    .rd    (rd)
`ifdef DM_COPY_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  task automatic set_mem(input int idx, input logic [DW-1:0] v);
    mem[idx] <= v;
  endtask

  // Issue one request and observe cycle by cycle (cycle k = k-th falling
  // edge after the accepting edge). Stops 'tail' cycles after the first done.
  // If extra_at > 0, a second start (src=0,dst=32,len=1) is pulsed in that cycle.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input int extra_at, input int tail,
                          output int done_cyc, output int we_cnt, output int busy_cnt,
                          output int done_cnt, output logic [DW-1:0] cks);
    int limit;
    done_cyc = 0; we_cnt = 0; busy_cnt = 0; done_cnt = 0; cks = '0;
    limit = 2 * int'(n) + 8;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = n;
    @(posedge clk);
    #1;
    // Input changes after acceptance must have no effect.
    start = 1'b0; src = 32'h3; dst = 32'h3; len = 16'd5;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (we) we_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
`ifdef DM_COPY_CHECKSUM_EN
          cks = checksum;
`endif
        end
      end
      if (c == extra_at) begin
        start = 1'b1; src = '0; dst = 32'd32; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (done_cyc != 0 && c >= done_cyc + tail) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < 64; i++) set_mem(i, 32'hA000_0000 | i);
    set_mem(8, 32'd2); set_mem(9, 32'd5); set_mem(10, 32'd7);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (a !== '0) begin errors++; $display("FAIL reset_a got=%h exp=0", a); end
    checks++; if (wd !== '0) begin errors++; $display("FAIL reset_wd got=%h exp=0", wd); end
`ifdef DM_COPY_CHECKSUM_EN
    checks++; if (checksum !== '0) begin errors++; $display("FAIL reset_checksum got=%h exp=0", checksum); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_copy_and_ignore();
    int dc, wc, bc, nc; logic [DW-1:0] ck;
    run_copy(32'd8, 32'd16, 16'd3, 2, 4, dc, wc, bc, nc, ck);
    checks++; if (mem[16] !== 32'd2) begin errors++; $display("FAIL copy_mem16 got=%h exp=2", mem[16]); end
    checks++; if (mem[17] !== 32'd5) begin errors++; $display("FAIL copy_mem17 got=%h exp=5", mem[17]); end
    checks++; if (mem[18] !== 32'd7) begin errors++; $display("FAIL copy_mem18 got=%h exp=7", mem[18]); end
    checks++; if (dc !== 7) begin errors++; $display("FAIL copy_done_cycle got=%0d exp=7", dc); end
    checks++; if (wc !== 3) begin errors++; $display("FAIL copy_we_count got=%0d exp=3", wc); end
    checks++; if (bc !== 6) begin errors++; $display("FAIL copy_busy_count got=%0d exp=6", bc); end
    checks++; if (nc !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", nc); end
    checks++; if (mem[32] !== 32'hA000_0020) begin errors++; $display("FAIL ignore_mem32 got=%h exp=a0000020", mem[32]); end
`ifdef DM_COPY_CHECKSUM_EN
    checks++; if (ck !== 32'd14) begin errors++; $display("FAIL checksum_at_done got=%0d exp=14", ck); end
`endif
  endtask

  task automatic test_zero_len();
    int dc, wc, bc, nc; logic [DW-1:0] ck;
    set_mem(16, 32'h0000_0055);
    run_copy(32'd8, 32'd16, 16'd0, 0, 2, dc, wc, bc, nc, ck);
    checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", dc); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL zero_busy_count got=%0d exp=0", bc); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL zero_we_count got=%0d exp=0", wc); end
    checks++; if (mem[16] !== 32'h55) begin errors++; $display("FAIL zero_mem16 got=%h exp=55", mem[16]); end
  endtask

  task automatic test_back_to_back();
    int dc, wc, bc, nc; logic [DW-1:0] ck;
    run_copy(32'd9, 32'd40, 16'd1, 0, 0, dc, wc, bc, nc, ck);
    checks++; if (dc !== 3) begin errors++; $display("FAIL b2b_first_done got=%0d exp=3", dc); end
    // Next request goes in during the IDLE cycle right after done.
    run_copy(32'd10, 32'd41, 16'd1, 0, 1, dc, wc, bc, nc, ck);
    checks++; if (dc !== 3) begin errors++; $display("FAIL b2b_second_done got=%0d exp=3", dc); end
    checks++; if (mem[40] !== 32'd5) begin errors++; $display("FAIL b2b_mem40 got=%h exp=5", mem[40]); end
    checks++; if (mem[41] !== 32'd7) begin errors++; $display("FAIL b2b_mem41 got=%h exp=7", mem[41]); end
  endtask

  task automatic test_reset_midway();
    set_mem(16, 32'hA000_0010); set_mem(17, 32'hA000_0011); set_mem(18, 32'hA000_0012);
    @(negedge clk);
    start = 1'b1; src = 32'd8; dst = 32'd16; len = 16'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);  // cycle 4 is the second WRITE
    checks++; if (we !== 1'b1 || a !== 32'd17) begin errors++; $display("FAIL rst_pre_write we=%b a=%h exp we=1 a=11", we, a); end
    rst_n = 1'b0;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we_drop got=%b exp=0", we); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || a !== '0) begin
      errors++; $display("FAIL rst_idle busy=%b done=%b a=%h exp 0/0/0", busy, done, a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem[16] !== 32'd2) begin errors++; $display("FAIL rst_mem16 got=%h exp=2", mem[16]); end
    checks++; if (mem[17] !== 32'hA000_0011) begin errors++; $display("FAIL rst_mem17 got=%h exp=a0000011", mem[17]); end
    checks++; if (mem[18] !== 32'hA000_0012) begin errors++; $display("FAIL rst_mem18 got=%h exp=a0000012", mem[18]); end
    checks++; if (busy !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL rst_stays_idle busy=%b we=%b exp 0/0", busy, we); end
  endtask

  task automatic test_overlap();
    int dc, wc, bc, nc; logic [DW-1:0] ck;
    set_mem(8, 32'd2); set_mem(9, 32'd5); set_mem(10, 32'd7);
    run_copy(32'd8, 32'd9, 16'd2, 0, 1, dc, wc, bc, nc, ck);
    checks++; if (mem[9] !== 32'd2) begin errors++; $display("FAIL overlap_mem9 got=%h exp=2", mem[9]); end
    checks++; if (mem[10] !== 32'd2) begin errors++; $display("FAIL overlap_mem10 got=%h exp=2", mem[10]); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL overlap_done_cycle got=%0d exp=5", dc); end
`ifdef DM_COPY_CHECKSUM_EN
    checks++; if (ck !== 32'd4) begin errors++; $display("FAIL overlap_checksum got=%0d exp=4", ck); end
`endif
  endtask

  task automatic test_wrap();
    int dc, wc, bc, nc; logic [DW-1:0] ck;
    set_mem(8, 32'd2); set_mem(9, 32'd5); set_mem(10, 32'd7);
    set_mem(0, 32'hA000_0000); set_mem(63, 32'hA000_003F);
    run_copy(32'd8, 32'hFFFF_FFFF, 16'd2, 0, 1, dc, wc, bc, nc, ck);
    checks++; if (mem[63] !== 32'd2) begin errors++; $display("FAIL wrap_mem63 got=%h exp=2", mem[63]); end
    checks++; if (mem[0] !== 32'd5) begin errors++; $display("FAIL wrap_mem0 got=%h exp=5", mem[0]); end
    checks++; if (wc !== 2) begin errors++; $display("FAIL wrap_we_count got=%0d exp=2", wc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_copy_and_ignore();
    test_zero_len();
    test_back_to_back();
    test_reset_midway();
    test_overlap();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dm_block_copy
